dram_cmd_issue: RTL and testbench
=================================

DRAM_CMD_ISSUE -- requirements
Module: dram_cmd_issue

Interface
REQ-001 Parameter NUMBER_OF_BANKS, 8, bank count; bank fields are $clog2(NUMBER_OF_BANKS) wide.
REQ-002 Parameter T_RCD, 3, cycles from the ACTIVATE pin cycle to cmd_ack.
REQ-003 Parameter T_RP, 3, cycles from the PRECHARGE pin cycle to cmd_ack.
REQ-004 Parameter T_CAS, 2, cycles from the READ/WRITE pin cycle to cmd_ack.
REQ-005 Parameter T_RAS, 6, minimum cycles from ACTIVATE to PRECHARGE on the same bank.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst_b  in  1  reset, asynchronous, active-low.
REQ-008 cmd_req  in  1  command request from the controller FSM.
REQ-009 cmd  in  2  command: 00 ACTIVATE, 01 READ, 10 WRITE, 11 PRECHARGE.
REQ-010 bank_rw  in  $clog2(NUMBER_OF_BANKS)  target bank.
REQ-011 cmd_ack  out  1  four-phase acknowledge.
REQ-012 dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n  out  1 each  DRAM command pins.
REQ-013 dram_ba  out  $clog2(NUMBER_OF_BANKS)  DRAM bank address.
REQ-014 bank_open  out  NUMBER_OF_BANKS  per-bank open-row flags.
REQ-015 protocol_err  out  1  one-cycle pulse on an illegal command.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT, ACK and RELEASE.
REQ-017 IDLE -> ISSUE when cmd_req=1 and cmd_ack=0; cmd and bank_rw are latched on that edge.
REQ-018 In ISSUE, for one cycle: dram_cs_n=0, dram_ba=latched bank. {ras_n,cas_n,we_n} = ACT 011, READ 101, WRITE 100, PRE 010.
REQ-019 Outside ISSUE the pins SHALL be deselect: cs_n=ras_n=cas_n=we_n=1, dram_ba=0.
REQ-020 ISSUE -> WAIT; the down-counter is loaded with latency-1. Latency is T_RCD for ACT, T_RP for PRE, T_CAS for READ/WRITE.
REQ-021 WAIT -> ACK when the counter reaches 0, so cmd_ack is first high exactly latency cycles after the ISSUE cycle.
REQ-022 cmd_ack=1 in ACK and RELEASE only. ACK -> RELEASE once cmd_req=0 is sampled. RELEASE -> IDLE after one cycle, with cmd_ack=0 from then on.
REQ-023 bank_open[b] is set in the ACT ISSUE cycle and cleared in the PRE ISSUE cycle for the latched bank.
REQ-024 ACT to an open bank, and READ/WRITE to a closed bank, are illegal.
REQ-025 For an illegal command: pins stay deselect, protocol_err=1 for the ISSUE cycle, bank_open is unchanged, latency=1.
REQ-026 PRECHARGE to a closed bank SHALL be legal and a pin-level no-op (pins driven, bank_open unchanged).
REQ-027 If cmd_req drops while in ISSUE or WAIT, the command completes and cmd_ack still rises. ACK then sees cmd_req=0 and cmd_ack stays high for exactly 2 cycles (ACK, RELEASE).
REQ-028 Latency counters SHALL be wide enough for max(T_RCD,T_RP,T_CAS,T_RAS) and SHALL saturate at 0.

Reset
REQ-029 While rst_b=0, asynchronously: state=IDLE, cmd_ack=0, protocol_err=0, pins deselect, dram_ba=0, bank_open=0, all counters 0.
REQ-030 Reset asserted mid-command abandons the command; after release the block samples cmd_req in IDLE on the first edge.

Configuration
REQ-031 Macro DRAM_CMD_TRAS_CHECK_EN: when defined, each bank has a counter loaded with T_RAS-1 on ACT ISSUE and decrementing to 0.
REQ-032 With the macro, a legal PRE to a bank with a nonzero counter SHALL wait in IDLE, without ISSUE, until that counter is 0. Other banks are unaffected.
REQ-033 Without the macro, no T_RAS counters exist and PRE issues immediately.

Verification
REQ-034 ACT bank 3 (req sampled edge 0) -> pins 011, ba=3, in cycle 1; cmd_ack high from cycle 4; bank_open[3]=1.
REQ-035 READ bank 3 with the bank open -> pins 101 for 1 cycle; cmd_ack 2 cycles later; req drop -> ack low 2 cycles later.
REQ-036 WRITE bank 5 while closed -> pins deselect, protocol_err pulse, cmd_ack 1 cycle after ISSUE.
REQ-037 With macro: ACT bank 2, then PRE bank 2 requested 2 cycles after the ACT ISSUE -> PRE ISSUE no earlier than 6 cycles after the ACT ISSUE. Without macro: PRE ISSUE immediately.
REQ-038 rst_b low during WAIT of an ACT -> cmd_ack=0, bank_open=0 immediately; a new ACT after release completes normally.

Source files
------------

// File: rtl/dram_cmd_issue_if.sv
// Controller-to-issuer command handshake plus the DRAM command pins and bank status.
// master: controller side; slave: dram_cmd_issue side.
interface dram_cmd_issue_if #(
  parameter int unsigned NUMBER_OF_BANKS = 8
);
  localparam int unsigned BankW = (NUMBER_OF_BANKS > 1) ? $clog2(NUMBER_OF_BANKS) : 1;

  logic                       cmd_req;
  logic [1:0]                 cmd;
  logic [BankW-1:0]           bank_rw;
  logic                       cmd_ack;
  logic                       dram_cs_n;
  logic                       dram_ras_n;
  logic                       dram_cas_n;
  logic                       dram_we_n;
  logic [BankW-1:0]           dram_ba;
  logic [NUMBER_OF_BANKS-1:0] bank_open;
  logic                       protocol_err;

  modport master (
    output cmd_req, cmd, bank_rw,
    input  cmd_ack, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_ba, bank_open,
           protocol_err
  );

  modport slave (
    input  cmd_req, cmd, bank_rw,
    output cmd_ack, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_ba, bank_open,
           protocol_err
  );
endinterface

// File: rtl/dram_cmd_issue.sv
// DRAM command issuer: four-phase req/ack, one-cycle pin drive, per-command latency, bank tracking.
// Optional DRAM_CMD_TRAS_CHECK_EN holds PRECHARGE in IDLE until the bank's tRAS window expires.
module dram_cmd_issue #(
  parameter int unsigned NUMBER_OF_BANKS = 8,
  parameter int unsigned T_RCD           = 3,
  parameter int unsigned T_RP            = 3,
  parameter int unsigned T_CAS           = 2,
  parameter int unsigned T_RAS           = 6
) (
  input logic             clk,
  input logic             rst_b,
  dram_cmd_issue_if.slave bus
);
  localparam int unsigned BankW  = (NUMBER_OF_BANKS > 1) ? $clog2(NUMBER_OF_BANKS) : 1;
  localparam int unsigned MaxA   = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned MaxB   = (T_CAS > T_RAS) ? T_CAS : T_RAS;
  localparam int unsigned MaxLat = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat + 1) : 1;

  localparam logic [1:0] CmdAct = 2'b00;
  localparam logic [1:0] CmdRd  = 2'b01;
  localparam logic [1:0] CmdWr  = 2'b10;
  localparam logic [1:0] CmdPre = 2'b11;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StAck, StRelease} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 cmd_q, cmd_d;
  logic [BankW-1:0]           bank_q, bank_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [NUMBER_OF_BANKS-1:0] open_q, open_d;

  logic             illegal;
  logic             pre_blocked;
  logic             cs_n, ack, err;
  logic [2:0]       rcw_n;
  logic [BankW-1:0] ba;

  // Latency minus one, so the counter reaches 0 on the cycle before cmd_ack rises.
  function automatic logic [CntW-1:0] lat_m1(input logic [1:0] c, input logic bad);
    int unsigned l;
    if (bad) begin
      l = 1;
    end else begin
      unique case (c)
        CmdAct:  l = T_RCD;
        CmdPre:  l = T_RP;
        default: l = T_CAS;
      endcase
    end
    if (l > 0) l = l - 1;
    return CntW'(l);
  endfunction

  assign illegal = ((cmd_q == CmdAct) && open_q[bank_q]) ||
                   (((cmd_q == CmdRd) || (cmd_q == CmdWr)) && !open_q[bank_q]);

`ifdef DRAM_CMD_TRAS_CHECK_EN
  localparam int unsigned RasLoad = (T_RAS > 0) ? T_RAS - 1 : 0;

  logic [NUMBER_OF_BANKS-1:0][CntW-1:0] ras_q, ras_d;

  always_comb begin
    for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
      ras_d[b] = (ras_q[b] == '0) ? '0 : ras_q[b] - CntW'(1);
    end
    if ((state_q == StIssue) && !illegal && (cmd_q == CmdAct)) begin
      ras_d[bank_q] = CntW'(RasLoad);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) ras_q <= '0;
    else        ras_q <= ras_d;
  end

  assign pre_blocked = (bus.cmd == CmdPre) && (ras_q[bus.bank_rw] != '0);
`else
  assign pre_blocked = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    open_d  = open_q;
    cs_n    = 1'b1;
    rcw_n   = 3'b111;
    ba      = '0;
    ack     = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_req && !pre_blocked) begin
          state_d = StIssue;
          cmd_d   = bus.cmd;
          bank_d  = bus.bank_rw;
        end
      end
      StIssue: begin
        if (illegal) begin
          err = 1'b1;
        end else begin
          cs_n = 1'b0;
          ba   = bank_q;
          unique case (cmd_q)
            CmdAct:  rcw_n = 3'b011;
            CmdRd:   rcw_n = 3'b101;
            CmdWr:   rcw_n = 3'b100;
            default: rcw_n = 3'b010;
          endcase
          if (cmd_q == CmdAct)      open_d[bank_q] = 1'b1;
          else if (cmd_q == CmdPre) open_d[bank_q] = 1'b0;
        end
        cnt_d   = lat_m1(cmd_q, illegal);
        // A one-cycle latency acks straight after ISSUE.
        state_d = (cnt_d == '0) ? StAck : StWait;
      end
      StWait: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);
        if (cnt_d == '0) state_d = StAck;
      end
      StAck: begin
        ack = 1'b1;
        if (!bus.cmd_req) state_d = StRelease;
      end
      StRelease: begin
        ack     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      bank_q  <= '0;
      cnt_q   <= '0;
      open_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      open_q  <= open_d;
    end
  end

  assign bus.cmd_ack      = ack;
  assign bus.protocol_err = err;
  assign bus.dram_cs_n    = cs_n;
  assign bus.dram_ras_n   = rcw_n[2];
  assign bus.dram_cas_n   = rcw_n[1];
  assign bus.dram_we_n    = rcw_n[0];
  assign bus.dram_ba      = ba;
  assign bus.bank_open    = open_q;
endmodule

// File: tb/tb_dram_cmd_issue.sv
// Scoreboard bench for dram_cmd_issue: a driver pushes model expectations, a monitor checks them.
// Honours DRAM_CMD_TRAS_CHECK_EN in its reference model.
module tb_dram_cmd_issue;
  localparam int unsigned NB   = 8;
  localparam int unsigned TRCD = 3;
  localparam int unsigned TRP  = 3;
  localparam int unsigned TCAS = 2;
  localparam int unsigned TRAS = 6;

  localparam logic [1:0] ACT = 2'b00;
  localparam logic [1:0] RD  = 2'b01;
  localparam logic [1:0] WR  = 2'b10;
  localparam logic [1:0] PRE = 2'b11;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  dram_cmd_issue_if #(.NUMBER_OF_BANKS(NB)) bus ();

  dram_cmd_issue #(
    .NUMBER_OF_BANKS(NB),
    .T_RCD          (TRCD),
    .T_RP           (TRP),
    .T_CAS          (TCAS),
    .T_RAS          (TRAS)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]    pins;  // {cs_n, ras_n, cas_n, we_n}
    logic [2:0]    ba;
    logic          err;
    int            lat;
    logic [NB-1:0] open_after;
    int            hold;
    int            earliest;
    int            latest;
  } exp_t;

  exp_t          sbq[$];
  logic [NB-1:0] model_open;
  int            act_cyc[NB];
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  initial forever @(posedge clk) cyc++;

  // Monitor: 0 = waiting for an issue, 1 = waiting for ack, 2 = measuring ack width.
  initial begin
    int   mph;
    int   mk;
    int   mhold;
    exp_t mit;
    mph = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        mph = 0;
      end else begin
        if (bus.dram_cs_n) begin
          chk("deselect_pins", {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n, bus.dram_ba},
              {3'b111, 3'b000});
        end
        case (mph)
          0: begin
            chk("ack_low_idle", bus.cmd_ack, 0);
            if (!bus.dram_cs_n || bus.protocol_err) begin
              if (sbq.size() == 0) begin
                timeout("unexpected_issue");
              end else begin
                mit = sbq.pop_front();
                chk("issue_pins", {bus.dram_cs_n, bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n},
                    mit.pins);
                chk("issue_ba", bus.dram_ba, mit.ba);
                chk("protocol_err", bus.protocol_err, mit.err);
                chk("issue_cycle_in_window", int'(cyc >= mit.earliest && cyc <= mit.latest), 1);
                mk  = 0;
                mph = 1;
              end
            end
          end
          1: begin
            mk++;
            chk("single_cycle_issue", int'(!bus.dram_cs_n || bus.protocol_err), 0);
            if (bus.cmd_ack) begin
              chk("ack_latency", mk, mit.lat);
              chk("bank_open", bus.bank_open, mit.open_after);
              mhold = 1;
              mph   = 2;
            end else if (mk > 40) begin
              timeout("ack_rise");
              mph = 0;
            end
          end
          default: begin
            if (bus.cmd_ack) begin
              mhold++;
              if (mhold > 60) begin
                timeout("ack_fall");
                mph = 0;
              end
            end else begin
              chk("ack_width", mhold, mit.hold);
              mph = 0;
            end
          end
        endcase
      end
    end
  end

  function automatic exp_t model_cmd(input logic [1:0] c, input int b, input int hold);
    exp_t e;
    logic legal;
    int   first;
    legal = !(((c == ACT) && model_open[b]) || (((c == RD) || (c == WR)) && !model_open[b]));
    first = cyc + 1;
    e.err = !legal;
    if (!legal) begin
      e.pins = 4'b1111;
      e.ba   = 3'b000;
      e.lat  = 1;
    end else begin
      e.ba = 3'(b);
      case (c)
        ACT:     begin e.pins = 4'b0011; e.lat = TRCD; end
        RD:      begin e.pins = 4'b0101; e.lat = TCAS; end
        WR:      begin e.pins = 4'b0100; e.lat = TCAS; end
        default: begin e.pins = 4'b0010; e.lat = TRP;  end
      endcase
    end
    e.earliest = first;
    e.latest   = first;
`ifdef DRAM_CMD_TRAS_CHECK_EN
    if (c == PRE && act_cyc[b] + int'(TRAS) > first) begin
      e.earliest = act_cyc[b] + int'(TRAS);
      e.latest   = e.earliest + 1;
    end
`endif
    if (legal && c == ACT) begin
      model_open[b] = 1'b1;
      act_cyc[b]    = first;
    end else if (legal && c == PRE) begin
      model_open[b] = 1'b0;
    end
    e.open_after = model_open;
    e.hold       = hold;
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with cmd_ack low.
  // mode 0..2: drop req that many cycles after ack rises; mode 3: drop req right after ISSUE.
  task automatic do_cmd(input logic [1:0] c, input int b, input int mode);
    bit ok;
    sbq.push_back(model_cmd(c, b, (mode == 3) ? 2 : 2 + mode));
    bus.cmd     = c;
    bus.bank_rw = 3'(b);
    bus.cmd_req = 1'b1;
    if (mode == 3) begin
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        ok = !bus.dram_cs_n || bus.protocol_err;
      end
      if (!ok) timeout("drv_issue");
      bus.cmd_req = 1'b0;
    end
    ok = bus.cmd_ack;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ack;
    end
    if (!ok) timeout("drv_ack_rise");
    if (mode != 3) begin
      repeat (mode) @(negedge clk);
      bus.cmd_req = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.cmd_ack;
    end
    if (!ok) timeout("drv_ack_fall");
  endtask

  task automatic clear_model();
    model_open = '0;
    for (int i = 0; i < NB; i++) act_cyc[i] = -1000;
  endtask

  initial begin
    bus.cmd_req = 1'b0;
    bus.cmd     = 2'b00;
    bus.bank_rw = 3'b000;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.cmd_ack, 0);
    chk("rst_err", bus.protocol_err, 0);
    chk("rst_bank_open", bus.bank_open, 0);
    chk("rst_cs_n", bus.dram_cs_n, 1);
    rst_b = 1'b1;
    @(negedge clk);

    // Directed: ACT/READ/illegal WRITE, tRAS-sensitive ACT->PRE, PRE to a closed bank.
    do_cmd(ACT, 3, 0);
    do_cmd(RD, 3, 1);
    do_cmd(WR, 5, 0);
    do_cmd(ACT, 2, 3);
    do_cmd(PRE, 2, 0);
    do_cmd(PRE, 6, 2);
    do_cmd(ACT, 3, 0);

    for (int n = 0; n < 150; n++) begin
      do_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, NB - 1)),
             int'($urandom_range(0, 3)));
    end

    // Reset during the WAIT of an ACT.
    do_cmd(PRE, 0, 0);
    sbq.push_back(model_cmd(ACT, 0, 2));
    bus.cmd     = ACT;
    bus.bank_rw = 3'd0;
    bus.cmd_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_bank_open0", bus.bank_open[0], 1);
    #2 rst_b = 1'b0;
    #1;
    chk("midrst_ack", bus.cmd_ack, 0);
    chk("midrst_bank_open", bus.bank_open, 0);
    chk("midrst_cs_n", bus.dram_cs_n, 1);
    sbq.delete();
    clear_model();
    bus.cmd_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    do_cmd(ACT, 0, 0);
    do_cmd(WR, 0, 1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
